// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and defaults for the WISC main-memory fill arbiter.
// Holds the FSM state, the grant encoding and the block-alignment helper.
package wisc_mem_pkg;

  localparam int unsigned MEM_LAT_DEF   = 4;
  localparam int unsigned BLK_WORDS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // Mask that clears the byte-offset-within-block bits (blocks of 16-bit words).
  function automatic logic [31:0] block_align_mask(input int unsigned blk_words);
    return ~((blk_words << 1) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_arb_rr2.sv
// Two-way round-robin arbiter between the I-side and D-side miss paths.
// The last grant is remembered so a conflict always favours the other side.
module arb_rr2
  import wisc_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ic_req_i,
  input  logic   dc_req_i,
  input  logic   take_i,
  output logic   valid_o,
  output grant_e gnt_o
);

  grant_e last_q;

  // NOTE: every output of an always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    valid_o = ic_req_i | dc_req_i;
    gnt_o   = GNT_I;
    if (ic_req_i && dc_req_i) begin
      gnt_o = (last_q == GNT_I) ? GNT_D : GNT_I;
    end else if (dc_req_i) begin
      gnt_o = GNT_D;
    end
  end

  // Reset to I so that the first conflict after reset goes to the D side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_I;
    end else if (take_i && valid_o) begin
      last_q <= gnt_o;
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the single-ported fixed-latency main memory between I-cache fills and
// D-cache fills/write-through stores, streaming returned words to the granted cache.
module cache_fill_arbiter
  import wisc_mem_pkg::*;
#(
  parameter  int unsigned MEM_LAT   = MEM_LAT_DEF,
  parameter  int unsigned BLK_WORDS = BLK_WORDS_DEF,
  parameter  int unsigned AW        = 16,
  parameter  int unsigned DW        = 16,
  localparam int unsigned WW        = $clog2(BLK_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ic_req,
  input  logic [AW-1:0] ic_addr,
  input  logic          dc_req,
  input  logic          dc_we,
  input  logic [AW-1:0] dc_addr,
  input  logic [DW-1:0] dc_wdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rdata_valid,
  input  logic [DW-1:0] mem_rdata,
  output logic          ic_fill_we,
  output logic          dc_fill_we,
  output logic [DW-1:0] fill_data,
  output logic [WW-1:0] fill_word,
  output logic          ic_done,
  output logic          dc_done,
  output logic          busy
);

  localparam logic [AW-1:0] BLK_MASK  = AW'(block_align_mask(BLK_WORDS));
  localparam logic [WW-1:0] LAST_WORD = WW'(BLK_WORDS - 1);
  // Reads in flight never exceed the memory latency, which sizes the counter.
  localparam int unsigned   OW        = $clog2(MEM_LAT + 1);

  state_e        state_q;
  grant_e        gnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [WW-1:0] issue_cnt_q;
  logic          issuing_q;
  logic [WW-1:0] ret_cnt_q;
  logic [OW-1:0] outst_q;
  logic [OW-1:0] outst_d;

  logic   arb_valid;
  grant_e arb_gnt;
  logic   fill_issue;
  logic   rd_accept;

  arb_rr2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ic_req_i (ic_req),
    .dc_req_i (dc_req),
    .take_i   (state_q == IDLE),
    .valid_o  (arb_valid),
    .gnt_o    (arb_gnt)
  );

  assign fill_issue = (state_q == FILL) && issuing_q;
  // A return is only taken while a read is outstanding, so stray valids never shift the word index.
  assign rd_accept  = (state_q == FILL) && mem_rdata_valid && (outst_q != '0);
  assign outst_d    = outst_q + OW'(fill_issue) - OW'(rd_accept);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_I;
      addr_q      <= '0;
      wdata_q     <= '0;
      issue_cnt_q <= '0;
      issuing_q   <= 1'b0;
      ret_cnt_q   <= '0;
      outst_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            gnt_q       <= arb_gnt;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            outst_q     <= '0;
            if (arb_gnt == GNT_D && dc_we) begin
              addr_q  <= dc_addr;
              wdata_q <= dc_wdata;
              state_q <= WRITE;
            end else begin
              addr_q    <= ((arb_gnt == GNT_D) ? dc_addr : ic_addr) & BLK_MASK;
              issuing_q <= 1'b1;
              state_q   <= FILL;
            end
          end
        end
        FILL: begin
          outst_q <= outst_d;
          if (issuing_q) begin
            issue_cnt_q <= issue_cnt_q + WW'(1);
            if (issue_cnt_q == LAST_WORD) issuing_q <= 1'b0;
          end
          if (rd_accept) begin
            ret_cnt_q <= ret_cnt_q + WW'(1);
            if (ret_cnt_q == LAST_WORD) state_q <= DONE;
          end
        end
        WRITE:   state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en    = fill_issue || (state_q == WRITE);
  assign mem_wr    = (state_q == WRITE);
  assign mem_addr  = (state_q == WRITE) ? addr_q :
                     fill_issue         ? addr_q + AW'({issue_cnt_q, 1'b0}) : '0;
  assign mem_wdata = (state_q == WRITE) ? wdata_q : '0;

  assign ic_fill_we = rd_accept && (gnt_q == GNT_I);
  assign dc_fill_we = rd_accept && (gnt_q == GNT_D);
  assign fill_data  = mem_rdata;
  assign fill_word  = ret_cnt_q;

  assign ic_done = (state_q == DONE) && (gnt_q == GNT_I);
  assign dc_done = (state_q == DONE) && (gnt_q == GNT_D);
  assign busy    = (ic_req & ~ic_done) | (dc_req & ~dc_done);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a 4-cycle fixed-latency memory model.
module tb_cache_fill_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req, dc_req, dc_we;
  logic [15:0] ic_addr, dc_addr, dc_wdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rdata_valid;
  logic [15:0] mem_rdata;
  logic        ic_fill_we, dc_fill_we;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        ic_done, dc_done, busy;
  logic        spur;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cache_fill_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ic_req          (ic_req),
    .ic_addr         (ic_addr),
    .dc_req          (dc_req),
    .dc_we           (dc_we),
    .dc_addr         (dc_addr),
    .dc_wdata        (dc_wdata),
    .mem_en          (mem_en),
    .mem_wr          (mem_wr),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .ic_fill_we      (ic_fill_we),
    .dc_fill_we      (dc_fill_we),
    .fill_data       (fill_data),
    .fill_word       (fill_word),
    .ic_done         (ic_done),
    .dc_done         (dc_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data returns LAT cycles after the read strobe; reset drops in-flight reads.
  logic        pipe_v [LAT];
  logic [15:0] pipe_a [LAT];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
      end
    end else begin
      pipe_v[0] <= mem_en & ~mem_wr;
      pipe_a[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  assign mem_rdata_valid = pipe_v[LAT-1] | spur;
  assign mem_rdata       = spur ? 16'hDEAD :
                           (pipe_v[LAT-1] ? mem_word(pipe_a[LAT-1]) : 16'h0000);

  typedef struct {
    logic        side_d;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_base;
    int          exp_done;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {6'd0, mem_en, mem_wr, mem_addr, mem_wdata, ic_fill_we, dc_fill_we,
            fill_data, fill_word, ic_done, dc_done, busy};
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    ic_req   = 1'b0;
    dc_req   = 1'b0;
    dc_we    = 1'b0;
    ic_addr  = '0;
    dc_addr  = '0;
    dc_wdata = '0;
    spur     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One isolated transaction: checks every strobe, every returned word and the done latency.
  task automatic run_txn(input vec_t v, input string tag);
    int c0, n_iss, n_ret;
    bit done_seen;
    @(posedge clk); #1;
    ic_req = !v.side_d;
    dc_req = v.side_d;
    dc_we  = v.we;
    if (v.side_d) begin
      dc_addr  = v.addr;
      dc_wdata = v.wdata;
    end else begin
      ic_addr = v.addr;
    end
    c0 = cyc;
    @(negedge clk);
    check({tag, " busy"}, 64'(busy), 64'(1));
    @(posedge clk); #1;
    ic_addr  = ~v.addr;
    dc_addr  = ~v.addr;
    dc_wdata = ~v.wdata;
    n_iss = 0;
    n_ret = 0;
    done_seen = 1'b0;
    for (int t = 0; t < 40 && !done_seen; t++) begin
      @(negedge clk);
      if (mem_en) begin
        if (v.we) begin
          check({tag, " store"}, 64'({mem_wr, mem_addr, mem_wdata}),
                64'({1'b1, v.exp_base, v.wdata}));
        end else begin
          check({tag, " issue"}, 64'({mem_wr, mem_addr}),
                64'({1'b0, v.exp_base + 16'(2 * n_iss)}));
        end
        check({tag, " issue cycle"}, 64'(cyc), 64'(c0 + 1 + n_iss));
        n_iss++;
      end
      if (ic_fill_we || dc_fill_we) begin
        if (!v.we) begin
          check({tag, " fill"}, 64'({ic_fill_we, dc_fill_we, fill_word, fill_data}),
                64'({!v.side_d, v.side_d, 3'(n_ret), mem_word(v.exp_base + 16'(2 * n_ret))}));
        end
        n_ret++;
      end
      if (ic_done || dc_done) begin
        done_seen = 1'b1;
        check({tag, " done"}, 64'({ic_done, dc_done, busy}), 64'({!v.side_d, v.side_d, 1'b0}));
        check({tag, " done cycle"}, 64'(cyc), 64'(c0 + v.exp_done));
      end
    end
    check({tag, " done seen"}, 64'(done_seen), 64'(1));
    check({tag, " counts"}, 64'({16'(n_iss), 16'(n_ret)}),
          64'({16'(v.we ? 1 : 8), 16'(v.we ? 0 : 8)}));
    @(posedge clk); #1;
    ic_req = 1'b0;
    dc_req = 1'b0;
    @(negedge clk);
    check({tag, " idle after"}, 64'({busy, mem_en}), 64'(0));
  endtask

  task automatic wait_done(input string tag, output logic got_d, output int at,
                           output int ni, output int nd);
    bit seen;
    seen  = 1'b0;
    got_d = 1'b0;
    at    = -1;
    ni    = 0;
    nd    = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (ic_fill_we) ni++;
      if (dc_fill_we) nd++;
      if (ic_done || dc_done) begin
        seen  = 1'b1;
        got_d = dc_done;
        at    = cyc;
      end
    end
    check({tag, " done seen"}, 64'(seen), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   c0, at, prev_at, ni, nd;
    logic gd;
    bit   seen;
    logic exp_side [3];

    //                side_d we    addr      wdata     exp_base  done
    vecs[0] = '{1'b0, 1'b0, 16'h0036, 16'h0000, 16'h0030, 13};
    vecs[1] = '{1'b1, 1'b1, 16'h1234, 16'hBEEF, 16'h1234, 2};
    vecs[2] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h00F0, 13};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'hFFF0, 13};
    vecs[4] = '{1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0000, 2};
    vecs[5] = '{1'b1, 1'b0, 16'h8010, 16'h0000, 16'h8010, 13};

    do_reset();
    @(negedge clk);
    check("reset outputs", all_outs(), 64'(0));

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Simultaneous requests after reset: D first, I granted in the IDLE after dc_done.
    do_reset();
    @(posedge clk); #1;
    ic_req  = 1'b1;
    ic_addr = 16'h0100;
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 16'h0208;
    c0 = cyc;
    wait_done("conflict first", gd, at, ni, nd);
    check("conflict first side", 64'(gd), 64'(1));
    check("conflict first cycle", 64'(at), 64'(c0 + 13));
    check("conflict first fills", 64'({16'(ni), 16'(nd)}), 64'({16'd0, 16'd8}));
    @(posedge clk); #1 dc_req = 1'b0;
    wait_done("conflict second", gd, at, ni, nd);
    check("conflict second side", 64'(gd), 64'(0));
    check("conflict second cycle", 64'(at), 64'(c0 + 27));
    check("conflict second fills", 64'({16'(ni), 16'(nd)}), 64'({16'd8, 16'd0}));
    @(posedge clk); #1 ic_req = 1'b0;

    // Both requests held: grants alternate D, I, D, one IDLE cycle between them.
    do_reset();
    exp_side[0] = 1'b1;
    exp_side[1] = 1'b0;
    exp_side[2] = 1'b1;
    @(posedge clk); #1;
    ic_req  = 1'b1;
    ic_addr = 16'h0300;
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 16'h0400;
    prev_at = cyc - 1;
    for (int k = 0; k < 3; k++) begin
      wait_done($sformatf("alternate %0d", k), gd, at, ni, nd);
      check($sformatf("alternate %0d side", k), 64'(gd), 64'(exp_side[k]));
      check($sformatf("alternate %0d spacing", k), 64'(at - prev_at), 64'(14));
      prev_at = at;
    end
    @(posedge clk); #1;
    ic_req = 1'b0;
    dc_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("alternate quiet", 64'({busy, mem_en}), 64'(0));
    end

    // Reset in the middle of a fill, then a clean refill from word 0.
    do_reset();
    @(posedge clk); #1;
    ic_req  = 1'b1;
    ic_addr = 16'h0040;
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (ic_fill_we && fill_word == 3'd3) seen = 1'b1;
    end
    check("midfill reached return 3", 64'(seen), 64'(1));
    rst_n  = 1'b0;
    ic_req = 1'b0;
    #1;
    check("midfill outputs in reset", all_outs(), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    run_txn(vecs[0], "refill");

    // Spurious read-valid in IDLE and during a store.
    do_reset();
    @(posedge clk); #1 spur = 1'b1;
    @(negedge clk);
    check("spurious idle fill_we", 64'({ic_fill_we, dc_fill_we}), 64'(0));
    @(posedge clk); #1 spur = 1'b0;
    @(negedge clk);
    check("spurious idle state", 64'({mem_en, busy, fill_word}), 64'(0));
    spur = 1'b1;
    run_txn(vecs[1], "spurious store");
    spur = 1'b0;
    run_txn(vecs[3], "fill after spurious");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
